// File: rtl/saturn_char_uart_tx.sv
// 8N1 UART transmitter fed by a small character FIFO; sits behind saturn_bus and
// drives the ESP32/USB console line plus the last-char LED bank.
module saturn_char_uart_tx #(
  parameter int CLK_HZ     = 25000000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          i_clk,
  input  logic                          i_reset_n,
  input  logic [7:0]                    i_char,
  input  logic                          i_char_valid,
  output logic                          o_char_ready,
  output logic                          o_tx,
  output logic                          o_busy,
  output logic [$clog2(FIFO_DEPTH):0]   o_fifo_count,
  output logic                          o_overflow,
  output logic [7:0]                    o_last_char,
  output logic [1:0]                    o_state
);

  localparam int DIV = (CLK_HZ + BAUD / 2) / BAUD;
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int NW  = AW + 1;
  localparam logic [CW-1:0] DIV_LAST = CW'(DIV - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t         state, state_next;
  logic [CW-1:0]  baud_cnt;
  logic [2:0]     bit_idx;
  logic [7:0]     shift;
  logic [7:0]     mem [FIFO_DEPTH];
  logic [AW-1:0]  wr_ptr, rd_ptr;
  logic [NW-1:0]  count;
  logic           push, pop, bit_end, line_next;

  // Handshake: a char is taken on any edge where i_char_valid && o_char_ready.
  // Ready depends only on the registered count, so a same-cycle pop never
  // makes room for a write into a full FIFO.
  assign o_char_ready = (count < NW'(FIFO_DEPTH));
  assign push         = i_char_valid && o_char_ready;
  assign bit_end      = (baud_cnt == DIV_LAST);
  assign o_busy       = (count != '0) || (state != IDLE);
  assign o_fifo_count = count;
  assign o_state      = state;

  always_comb begin
    state_next = state;
    pop        = 1'b0;
    line_next  = 1'b1;
    case (state)
      IDLE: begin
        if (count != '0) begin
          pop        = 1'b1;
          state_next = START;
        end
      end
      START: begin
        line_next = 1'b0;
        if (bit_end) state_next = DATA;
      end
      DATA: begin
        line_next = shift[0];
        if (bit_end && bit_idx == 3'd7) state_next = STOP;
      end
      STOP: begin
        line_next = 1'b1;
        // Reloading straight from STOP keeps frames back to back with no idle gap.
        if (bit_end) begin
          if (count != '0) begin
            pop        = 1'b1;
            state_next = START;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) state <= IDLE;
    else            state <= state_next;
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      baud_cnt <= '0;
      bit_idx  <= 3'd0;
      shift    <= 8'd0;
      o_tx     <= 1'b1;
    end else begin
      o_tx <= line_next;
      if (state == IDLE || bit_end) baud_cnt <= '0;
      else                          baud_cnt <= baud_cnt + CW'(1);
      if (pop) begin
        shift   <= mem[rd_ptr];
        bit_idx <= 3'd0;
      end else if (state == DATA && bit_end) begin
        shift   <= {1'b0, shift[7:1]};
        bit_idx <= bit_idx + 3'd1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      o_overflow  <= 1'b0;
      o_last_char <= 8'd0;
    end else begin
      if (push) begin
        wr_ptr      <= wr_ptr + AW'(1);
        o_last_char <= i_char;
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + NW'(push) - NW'(pop);
      if (i_char_valid && !o_char_ready) o_overflow <= 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (push) mem[wr_ptr] <= i_char;
  end

endmodule
